// File: rtl/mctrl_pkg.sv
// mctrl_pkg: state encoding, opcodes and ALU operation codes shared by the multi-cycle controller
package mctrl_pkg;
    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_IF    = 3'd1,
        S_DEC   = 3'd2,
        S_EXEC  = 3'd3,
        S_MEM   = 3'd4,
        S_WB    = 3'd5
    } state_t;
    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
endpackage

// File: rtl/mctrl_decode.sv
// mctrl_decode: combinational opcode-to-class decoder
// Ports: opc (6-bit opcode) -> rtype, imm, branch, load, store, illegal class flags
module mctrl_decode
    import mctrl_pkg::*;
(
    input  logic [5:0] opc,
    output logic       rtype,
    output logic       imm,
    output logic       branch,
    output logic       load,
    output logic       store,
    output logic       illegal
);
    assign rtype   = opc == OP_RTYPE;
    assign imm     = opc inside {OP_LI, OP_LUI, OP_ADDI, OP_ANDI, OP_ORI};
    assign branch  = opc inside {OP_B, OP_BEQ, OP_BNE};
    assign load    = opc inside {OP_LW, OP_LB};
    assign store   = opc inside {OP_SW, OP_SB};
    assign illegal = !(rtype || imm || branch || load || store);
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle control sequencer (IF/DEC/EXEC/MEM/WB) with retired-instruction counter
// Inputs : clk, Reset (sync, active-high), Instr[31:0], Zero, Mem_Ready (only with MCTRL_MEM_WAIT_EN)
// Outputs: datapath controls (PC_sel, PC_LdEn, IR/AB/ALUreg/MDR load enables, RF_WrEn, RF_WrData_sel,
//          RF_B_sel, ALU_Bin_sel, ALU_func, Mem_WrEn), mode flags lui/lb/sb, Illegal pulse,
//          State (debug), Instr_cnt
// Option : define MCTRL_MEM_WAIT_EN to stall S_MEM until Mem_Ready
module multicycle_ctrl_fsm
    import mctrl_pkg::*;
#(
    parameter int RESET_HOLD = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [31:0]      Instr,
    input  logic             Zero,
`ifdef MCTRL_MEM_WAIT_EN
    input  logic             Mem_Ready,
`endif
    output logic             PC_sel,
    output logic             PC_LdEn,
    output logic             IR_LdEn,
    output logic             AB_LdEn,
    output logic             ALUreg_LdEn,
    output logic             MDR_LdEn,
    output logic             RF_WrEn,
    output logic             RF_WrData_sel,
    output logic             RF_B_sel,
    output logic             ALU_Bin_sel,
    output logic [3:0]       ALU_func,
    output logic             Mem_WrEn,
    output logic             lui,
    output logic             lb,
    output logic             sb,
    output logic             Illegal,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] Instr_cnt
);
    state_t           state, next;
    logic [3:0]       hold;
    logic [5:0]       opc;
    logic [3:0]       func;
    logic [CNT_W-1:0] cnt;
    logic             retire, mem_ready, active;
    logic             rtype, imm, branch, load, store, illegal;
    logic             unused_instr;

`ifdef MCTRL_MEM_WAIT_EN
    assign mem_ready = Mem_Ready;
`else
    assign mem_ready = 1'b1;
`endif
    // only the opcode and function fields are consumed here
    assign unused_instr = ^Instr[25:4];
    // outputs are forced low while Reset is held so an aborted instruction never writes
    assign active    = !Reset;
    assign State     = active ? state : S_RESET;
    assign Instr_cnt = active ? cnt : '0;

    mctrl_decode u_decode (
        .opc(opc), .rtype(rtype), .imm(imm), .branch(branch),
        .load(load), .store(store), .illegal(illegal)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state <= S_RESET;
            hold  <= 4'(RESET_HOLD);
            opc   <= '0;
            func  <= '0;
            cnt   <= '0;
        end else begin
            state <= next;
            if (state == S_RESET) hold <= hold - 4'd1;
            if (state == S_IF) begin
                opc  <= Instr[31:26];
                func <= Instr[3:0];
            end
            if (retire) cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        next          = state;
        retire        = 1'b0;
        PC_sel        = 1'b0;
        PC_LdEn       = 1'b0;
        IR_LdEn       = 1'b0;
        AB_LdEn       = 1'b0;
        ALUreg_LdEn   = 1'b0;
        MDR_LdEn      = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_B_sel      = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = ALU_ADD;
        Mem_WrEn      = 1'b0;
        Illegal       = 1'b0;
        lui           = active && state inside {S_DEC, S_EXEC, S_MEM, S_WB} && opc == OP_LUI;
        lb            = active && state inside {S_DEC, S_EXEC, S_MEM, S_WB} && opc == OP_LB;
        sb            = active && state inside {S_DEC, S_EXEC, S_MEM, S_WB} && opc == OP_SB;
        if (active) begin
            case (state)
                // hold counts the cycles still to spend here; leave as it reaches zero
                S_RESET: next = (hold <= 4'd1) ? S_IF : S_RESET;
                S_IF: begin
                    IR_LdEn = 1'b1;
                    next    = S_DEC;
                end
                S_DEC: begin
                    AB_LdEn  = 1'b1;
                    RF_B_sel = !rtype;
                    Illegal  = illegal;
                    PC_LdEn  = illegal;
                    next     = illegal ? S_IF : S_EXEC;
                end
                S_EXEC: begin
                    ALUreg_LdEn = 1'b1;
                    ALU_Bin_sel = imm || load || store;
                    ALU_func    = rtype ? func :
                                  opc == OP_ANDI ? ALU_AND :
                                  opc == OP_ORI ? ALU_OR :
                                  (opc == OP_BEQ || opc == OP_BNE) ? ALU_SUB : ALU_ADD;
                    PC_LdEn     = branch;
                    PC_sel      = branch && (opc == OP_B || (opc == OP_BEQ ? Zero : !Zero));
                    retire      = branch;
                    next        = branch ? S_IF : (load || store) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    Mem_WrEn = store;
                    MDR_LdEn = load && mem_ready;
                    PC_LdEn  = store && mem_ready;
                    retire   = store && mem_ready;
                    next     = !mem_ready ? S_MEM : store ? S_IF : S_WB;
                end
                S_WB: begin
                    RF_WrEn       = 1'b1;
                    RF_WrData_sel = load;
                    PC_LdEn       = 1'b1;
                    retire        = 1'b1;
                    next          = S_IF;
                end
                default: next = S_RESET;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: randomized self-checking bench comparing every cycle against a phase-list model
module tb_multicycle_ctrl_fsm;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Zero = 1'b0;
    logic [31:0] Instr = '0;
`ifdef MCTRL_MEM_WAIT_EN
    logic        Mem_Ready = 1'b1;
`endif
    logic        PC_sel, PC_LdEn, IR_LdEn, AB_LdEn, ALUreg_LdEn, MDR_LdEn, RF_WrEn;
    logic        RF_WrData_sel, RF_B_sel, ALU_Bin_sel, Mem_WrEn, lui, lb, sb, Illegal;
    logic [3:0]  ALU_func;
    logic [2:0]  State;
    logic [3:0]  Instr_cnt;
    logic [25:0] got;
    logic [3:0]  cnt_model = '0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.RESET_HOLD(2), .CNT_W(4)) dut (
        .clk(clk), .Reset(Reset), .Instr(Instr), .Zero(Zero),
`ifdef MCTRL_MEM_WAIT_EN
        .Mem_Ready(Mem_Ready),
`endif
        .PC_sel(PC_sel), .PC_LdEn(PC_LdEn), .IR_LdEn(IR_LdEn), .AB_LdEn(AB_LdEn),
        .ALUreg_LdEn(ALUreg_LdEn), .MDR_LdEn(MDR_LdEn), .RF_WrEn(RF_WrEn),
        .RF_WrData_sel(RF_WrData_sel), .RF_B_sel(RF_B_sel), .ALU_Bin_sel(ALU_Bin_sel),
        .ALU_func(ALU_func), .Mem_WrEn(Mem_WrEn), .lui(lui), .lb(lb), .sb(sb),
        .Illegal(Illegal), .State(State), .Instr_cnt(Instr_cnt)
    );

    assign got = {State, PC_sel, PC_LdEn, IR_LdEn, AB_LdEn, ALUreg_LdEn, MDR_LdEn, RF_WrEn,
                  RF_WrData_sel, RF_B_sel, ALU_Bin_sel, ALU_func, Mem_WrEn, lui, lb, sb,
                  Illegal, Instr_cnt};

    // instruction class: 0 R-type, 1 immediate, 2 branch, 3 load, 4 store, 5 undefined
    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b100000: return 0;
            6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011: return 1;
            6'b111111, 6'b000000, 6'b000001: return 2;
            6'b001111, 6'b000011: return 3;
            6'b011111, 6'b000111: return 4;
            default: return 5;
        endcase
    endfunction

    // expected outputs for one cycle, given the phase (1 IF .. 5 WB) and where it sits in the instruction
    function automatic logic [25:0] exp_vec(input int ph, input logic [5:0] op, input logic [3:0] fn,
                                            input logic z, input bit last, input bit rdy,
                                            input logic [3:0] c);
        int k;
        logic [3:0] alu;
        logic psel, inst;
        k    = kind_of(op);
        psel = last && k == 2 && (op == 6'b111111 ? 1'b1 : op == 6'b000000 ? z : !z);
        alu  = ph != 3 ? 4'd0 : k == 0 ? fn : op == 6'b110010 ? 4'd2 : op == 6'b110011 ? 4'd3 :
               (op == 6'b000000 || op == 6'b000001) ? 4'd1 : 4'd0;
        inst = ph >= 2;
        return {3'(ph), psel, last, ph == 1, ph == 2, ph == 3, ph == 4 && k == 3 && rdy,
                ph == 5, ph == 5 && k == 3, ph == 2 && k != 0, ph == 3 && (k == 1 || k == 3 || k == 4),
                alu, ph == 4 && k == 4, inst && op == 6'b111001, inst && op == 6'b000011,
                inst && op == 6'b000111, ph == 2 && k == 5, c};
    endfunction

    // runs one instruction starting in IF, waiting w cycles for memory, checking every cycle
    task automatic run_instr(input string name, input logic [5:0] op, input logic [3:0] fn,
                             input logic z, input int w);
        int ph[$];
        int k;
        int mi;
        bit last, rdy;
        logic [25:0] exp;
        k  = kind_of(op);
        mi = 0;
        ph = {1, 2};
        if (k != 5) ph.push_back(3);
        if (k == 3 || k == 4) repeat (w + 1) ph.push_back(4);
        if (k <= 1 || k == 3) ph.push_back(5);
        for (int i = 0; i < ph.size(); i++) begin
            @(negedge clk);
            if (i == 0) begin
                Instr = {op, 22'($urandom), fn};
                Zero  = z;
            end
            rdy = !(ph[i] == 4 && mi < w);
`ifdef MCTRL_MEM_WAIT_EN
            Mem_Ready = rdy;
`endif
            #1;
            last = i == ph.size() - 1;
            exp  = exp_vec(ph[i], op, fn, z, last, rdy, cnt_model);
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s cycle %0d op=%b got=%h expected=%h", name, i, op, got, exp);
            end
            if (ph[i] == 4) mi++;
        end
        if (k != 5) cnt_model++;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            tests++;
            if (got !== '0) begin
                fails++;
                $display("FAIL reset_held got=%h expected=0", got);
            end
        end
        Reset = 1'b0;
        cnt_model = '0;
        for (int i = 0; i < 2; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            tests++;
            if (got !== '0) begin
                fails++;
                $display("FAIL reset_release cycle %0d got=%h expected=0", i, got);
            end
        end
    endtask

    task automatic test_rtype();
        run_instr("rtype_add", 6'b100000, 4'b0000, 1'b0, 0);
        @(posedge clk);
        #1;
        tests++;
        if (Instr_cnt !== 4'd1) begin
            fails++;
            $display("FAIL rtype_count got=%0d expected=1", Instr_cnt);
        end
        run_instr("rtype_func", 6'b100000, 4'b1010, 1'b1, 0);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", 6'b000000, 4'h0, 1'b1, 0);
        run_instr("beq_not", 6'b000000, 4'h0, 1'b0, 0);
        run_instr("bne_taken", 6'b000001, 4'h0, 1'b0, 0);
        run_instr("b_always", 6'b111111, 4'h0, 1'b0, 0);
    endtask

    task automatic test_load_store();
        run_instr("lw", 6'b001111, 4'h5, 1'b0, 0);
        run_instr("sb", 6'b000111, 4'h5, 1'b0, 0);
        run_instr("lb", 6'b000011, 4'h0, 1'b1, 0);
        run_instr("sw", 6'b011111, 4'h0, 1'b1, 0);
        run_instr("lui", 6'b111001, 4'h3, 1'b0, 0);
        run_instr("andi", 6'b110010, 4'h3, 1'b0, 0);
        run_instr("ori", 6'b110011, 4'h3, 1'b0, 0);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 6'b101010, 4'h0, 1'b0, 0);
        run_instr("after_illegal", 6'b110000, 4'h0, 1'b0, 0);
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        Instr = {6'b001111, 26'h0};
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (State !== 3'd3) begin
            fails++;
            $display("FAIL abort_exec state got=%0d expected=3", State);
        end
        Reset = 1'b1;
        #1;
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL abort_gated got=%h expected=0", got);
        end
        @(negedge clk);
        Reset = 1'b0;
        cnt_model = '0;
        #1;
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL abort_after got=%h expected=0", got);
        end
        @(negedge clk);
        #1;
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL abort_hold got=%h expected=0", got);
        end
    endtask

`ifdef MCTRL_MEM_WAIT_EN
    task automatic test_mem_wait();
        run_instr("sw_wait4", 6'b011111, 4'h0, 1'b0, 4);
        run_instr("lw_wait2", 6'b001111, 4'h0, 1'b0, 2);
    endtask
`endif

    task automatic test_random();
        logic [5:0] ops [13] = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011,
                                 6'b111111, 6'b000000, 6'b000001, 6'b001111, 6'b000011,
                                 6'b011111, 6'b000111};
        logic [5:0] op;
        int w;
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 12)];
            w  = 0;
`ifdef MCTRL_MEM_WAIT_EN
            w  = $urandom_range(0, 3);
`endif
            run_instr("random", op, 4'($urandom), 1'($urandom), w);
        end
    endtask

    task automatic test_wrap();
        while (cnt_model != 4'd15) run_instr("wrap_fill", 6'b110000, 4'h0, 1'b0, 0);
        run_instr("wrap_last", 6'b100000, 4'h1, 1'b0, 0);
        @(posedge clk);
        #1;
        tests++;
        if (Instr_cnt !== 4'd0) begin
            fails++;
            $display("FAIL wrap got=%0d expected=0", Instr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_branch();
        test_load_store();
        test_illegal();
        test_reset_abort();
        run_instr("post_abort", 6'b100000, 4'h2, 1'b0, 0);
`ifdef MCTRL_MEM_WAIT_EN
        test_mem_wait();
`endif
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
